// File: rtl/alu_pkg.sv
// Shared execute-stage types: multiply/divide opcodes, unit FSM states and counter sizing.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(XLEN);

    // Encodings follow instruction funct3 so the decoder can pass it straight through.
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Operand/result handshake bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    Result;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, Result
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, Result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-subtract step per cycle on magnitudes,
// followed by a single sign-fix cycle.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = XLEN,
    parameter int unsigned OPCODE_LENGTH = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    muldiv_unit_if.slave bus
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned W2 = 2 * DATA_WIDTH;
    localparam int unsigned CW = cnt_width(DATA_WIDTH);

    state_e          state_q, state_d;
    muldiv_op_e      op_q, op_d;
    logic [W-1:0]    addend_q, addend_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    result_q, result_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [OPCODE_LENGTH-1:0] op_raw;
    muldiv_op_e      op_in;
    logic            sa, sb, a_signed, b_signed, neg_in;
    logic [W-1:0]    abs_a, abs_b;
    logic            div_zero, div_ovf, special_in;
    logic [W-1:0]    special_res;

    assign op_raw   = bus.Operation;
    assign op_in    = muldiv_op_e'(op_raw);
    assign sa       = bus.SrcA[W-1];
    assign sb       = bus.SrcB[W-1];
    assign a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
    assign b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    assign abs_a    = (a_signed && sa) ? (~bus.SrcA + W'(1)) : bus.SrcA;
    assign abs_b    = (b_signed && sb) ? (~bus.SrcB + W'(1)) : bus.SrcB;

    // Product sign for MULH*, quotient sign for DIV, dividend sign for REM.
    always_comb begin
        neg_in = 1'b0;
        case (op_in)
            OP_MULH, OP_DIV: neg_in = sa ^ sb;
            OP_MULHSU, OP_REM: neg_in = sa;
            default: neg_in = 1'b0;
        endcase
    end

    assign div_zero   = op_in[2] && (bus.SrcB == '0);
    assign div_ovf    = ((op_in == OP_DIV) || (op_in == OP_REM))
                        && (bus.SrcA == {1'b1, {(W-1){1'b0}}}) && (bus.SrcB == '1);
    assign special_in = div_zero || div_ovf;
    // op bit 1 separates REM/REMU from DIV/DIVU.
    assign special_res = div_zero ? (op_in[1] ? bus.SrcA : '1)
                                  : (op_in[1] ? '0 : {1'b1, {(W-1){1'b0}}});

    // Shared W+1-bit adder: conditional add of the multiplicand, or trial subtract of the divisor.
    logic [W:0]    add_a, add_b, sum;
    logic          add_cin;
    logic [W2-1:0] step_acc;

    always_comb begin
        if (op_q[2]) begin
            add_a   = acc_q[W2-1:W-1];
            add_b   = ~{1'b0, addend_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, acc_q[W2-1:W]};
            add_b   = acc_q[0] ? {1'b0, addend_q} : '0;
            add_cin = 1'b0;
        end
        sum = add_a + add_b + (W+1)'(add_cin);
        if (!op_q[2]) begin
            step_acc = {sum, acc_q[W-1:1]};
        end else if (sum[W]) begin
            step_acc = {acc_q[W2-2:0], 1'b0};
        end else begin
            step_acc = {sum[W-1:0], acc_q[W-2:0], 1'b1};
        end
    end

    logic [W2-1:0] prod_fix;
    logic [W-1:0]  q_fix, r_fix, fix_res;

    assign prod_fix = neg_q ? (~acc_q + W2'(1)) : acc_q;
    assign q_fix    = neg_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
    assign r_fix    = neg_q ? (~acc_q[W2-1:W] + W'(1)) : acc_q[W2-1:W];

    always_comb begin
        case (op_q)
            OP_MUL: fix_res = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[W2-1:W];
            OP_DIV, OP_DIVU: fix_res = q_fix;
            default: fix_res = r_fix;
        endcase
    end

    // Next state and next register values.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addend_d = addend_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q && !flush) begin
                    op_d  = op_in;
                    neg_d = neg_in;
                    if (special_in) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = CW'(W);
                        state_d = CALC;
                        if (op_in[2]) begin
                            acc_d    = {W'(0), abs_a};
                            addend_d = abs_b;
                        end else begin
                            acc_d    = {W'(0), abs_b};
                            addend_d = abs_a;
                        end
                    end
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                if (!flush) result_d = fix_res;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_MUL;
            addend_q    <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addend_q    <= addend_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, random ops against a 64-bit model,
// backpressure, flush and asynchronous reset.
module tb_muldiv_unit;
    import alu_pkg::*;

    localparam int unsigned W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    muldiv_unit_if #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) bus ();

    muldiv_unit #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    int           lat_q[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] model(input muldiv_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            OP_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
            OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            OP_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
            OP_DIV: begin
                if (b == '0) return '1;
                if (a == MIN && b == '1) return MIN;
                return W'(sa / sb);
            end
            OP_DIVU: begin
                if (b == '0) return '1;
                return W'(ua / ub);
            end
            OP_REM: begin
                if (b == '0) return a;
                if (a == MIN && b == '1) return '0;
                return W'(sa % sb);
            end
            default: begin
                if (b == '0) return a;
                return W'(ua % ub);
            end
        endcase
    endfunction

    function automatic bit is_special(input muldiv_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (!op[2]) return 1'b0;
        if (b == '0) return 1'b1;
        return ((op == OP_DIV) || (op == OP_REM)) && (a == MIN) && (b == '1);
    endfunction

    // Called at a negedge in IDLE; returns at the negedge one cycle after the accept edge.
    task automatic issue(input muldiv_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp);
        exp_q.push_back(exp);
        lat_q.push_back(is_special(op, a, b) ? 1 : W + 2);
        check("in_ready_before_issue", W'(bus.in_ready), W'(1));
        bus.in_valid  = 1'b1;
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.SrcA      = $urandom;
        bus.SrcB      = $urandom;
        bus.Operation = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_result(input string tag);
        logic [CNT_W+1:0] lat;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, W'(bus.out_valid), W'(1));
        check({tag, "_latency"}, W'(lat), W'(lat_q.pop_front()));
        check(tag, bus.Result, exp_q.pop_front());
    endtask

    task automatic run(input muldiv_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input string tag);
        issue(op, a, b, exp);
        wait_result(tag);
        @(negedge clk);
        check({tag, "_release_ready"}, W'(bus.in_ready), W'(1));
        check({tag, "_release_valid"}, W'(bus.out_valid), W'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        muldiv_op_e rop;
        logic [W-1:0] ra, rb;
        logic seen;

        bus.in_valid  = 1'b0;
        bus.Operation = '0;
        bus.SrcA      = '0;
        bus.SrcB      = '0;
        bus.out_ready = 1'b1;

        #12;
        check("reset_in_ready", W'(bus.in_ready), W'(1));
        check("reset_out_valid", W'(bus.out_valid), W'(0));
        check("reset_result", bus.Result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
        run(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run(OP_MULH,   MIN,            MIN,           32'h4000_0000, "mulh_min");
        run(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        run(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2");
        run(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2");
        run(OP_DIVU,   32'd100,        32'd7,         32'd14,        "divu_100_7");
        run(OP_REMU,   32'd100,        32'd7,         32'd2,         "remu_100_7");
        run(OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, "div_by_zero");
        run(OP_REM,    32'd5,          32'd0,         32'd5,         "rem_by_zero");
        run(OP_DIV,    MIN,            32'hFFFF_FFFF, MIN,           "div_ovf");
        run(OP_REM,    MIN,            32'hFFFF_FFFF, 32'd0,         "rem_ovf");

        for (int i = 0; i < 8; i++) begin
            rop = muldiv_op_e'(3'($urandom_range(0, 7)));
            ra  = $urandom;
            rb  = (i == 3) ? '0 : ((i == 5) ? 32'($urandom_range(1, 9)) : $urandom);
            run(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d_op%0d", i, rop));
        end

        // Backpressure: result must hold while the consumer stalls.
        bus.out_ready = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14);
        wait_result("bp_divu");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", W'(bus.out_valid), W'(1));
            check("bp_hold_result", bus.Result, 32'd14);
            check("bp_hold_in_ready", W'(bus.in_ready), W'(0));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", W'(bus.out_valid), W'(0));
        check("bp_release_ready", W'(bus.in_ready), W'(1));

        // Flush at cycle 15 of a DIV.
        bus.in_valid  = 1'b1;
        bus.Operation = OP_DIV;
        bus.SrcA      = 32'hFFFF_FFF9;
        bus.SrcB      = 32'd2;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", W'(bus.in_ready), W'(1));
        check("flush_out_valid", W'(bus.out_valid), W'(0));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_no_result", W'(seen), W'(0));
        check("flush_result_held", bus.Result, 32'd14);

        // Flush wins over a simultaneous in_valid.
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.Operation = OP_MUL;
        bus.SrcA      = 32'd3;
        bus.SrcB      = 32'd4;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_blocks_accept", W'(bus.in_ready), W'(1));
        @(negedge clk);
        check("flush_blocks_valid", W'(bus.out_valid), W'(0));

        // Asynchronous reset mid-MUL.
        bus.in_valid  = 1'b1;
        bus.Operation = OP_MUL;
        bus.SrcA      = 32'd7;
        bus.SrcB      = 32'hFFFF_FFFD;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_busy", W'(bus.in_ready), W'(0));
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_in_ready", W'(bus.in_ready), W'(1));
        check("async_reset_out_valid", W'(bus.out_valid), W'(0));
        check("async_reset_result", bus.Result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(OP_MULHU, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, "post_reset_mulhu");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
